// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and post-reset clear sweep.
module dual_port_ram_be #(
  parameter int                 DATA_W       = 32,
  parameter int                 ADDR_W       = 6,
  parameter int                 RD_MODE      = 0,
  parameter int                 OUT_REG      = 0,
  parameter int                 CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [DATA_W/8-1:0]   be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     din_a,
  output logic [DATA_W-1:0]     dout_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     din_b,
  output logic [DATA_W-1:0]     dout_b,
  output logic                  valid_b,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake: an access is taken in any cycle with en_x=1 and init_busy=0
  // (no backpressure); its data appears RD_LAT cycles later with a one-cycle valid_x.

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t          clr_state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                busy_q;
  logic                clr_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_a, acc_b, wr_a, wr_b, same_addr;
  logic                prod_a, prod_b;
  logic [DATA_W-1:0]   old_a, old_b, new_a, new_b, rdata_a, rdata_b;

  logic [DATA_W-1:0]   d1_a, d1_b;
  logic                v1_a, v1_b, coll_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
      if (CLEAR_ON_RST != 0) begin
        clr_state <= CLEAR;
        busy_q    <= 1'b1;
      end else begin
        clr_state <= IDLE;
        busy_q    <= 1'b0;
      end
    end else if (clr_state == CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (clr_cnt == {ADDR_W{1'b1}}) begin
        clr_state <= IDLE;
        busy_q    <= 1'b0;
      end
    end
  end

  assign clr_we    = (clr_state == CLEAR) && !rst;
  assign init_busy = busy_q;

  assign acc_a     = en_a && !busy_q && !rst;
  assign acc_b     = en_b && !busy_q && !rst;
  assign wr_a      = acc_a && we_a;
  assign wr_b      = acc_b && we_b;
  assign same_addr = (addr_a == addr_b);

  // new_x is the word at addr_x after both ports' writes land; port A owns shared bytes.
  always_comb begin
    old_a = mem[addr_a];
    old_b = mem[addr_b];
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && be_a[i])
        new_a[8*i +: 8] = din_a[8*i +: 8];
      else if (wr_b && be_b[i] && same_addr)
        new_a[8*i +: 8] = din_b[8*i +: 8];
      if (wr_a && be_a[i] && same_addr)
        new_b[8*i +: 8] = din_a[8*i +: 8];
      else if (wr_b && be_b[i])
        new_b[8*i +: 8] = din_b[8*i +: 8];
    end
    rdata_a = (RD_MODE == 1 && wr_a) ? new_a : old_a;
    rdata_b = (RD_MODE == 1 && wr_b) ? new_b : old_b;
    prod_a  = acc_a && !(RD_MODE == 2 && we_a);
    prod_b  = acc_b && !(RD_MODE == 2 && we_b);
  end

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_cnt] <= INIT_VAL;
    for (int i = 0; i < NB; i++) begin
      if (wr_b && be_b[i])
        mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      if (wr_a && be_a[i])
        mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_a   <= '0;
      d1_b   <= '0;
      v1_a   <= 1'b0;
      v1_b   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      v1_a   <= prod_a;
      v1_b   <= prod_b;
      if (prod_a) d1_a <= rdata_a;
      if (prod_b) d1_b <= rdata_b;
      coll_q <= wr_a && wr_b && same_addr && ((be_a & be_b) != '0);
    end
  end

  assign collision = coll_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] d2_a, d2_b;
      logic              v2_a, v2_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          d2_a <= '0;
          d2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end

      assign dout_a  = d2_a;
      assign dout_b  = d2_b;
      assign valid_a = v2_a;
      assign valid_b = v2_b;
    end else begin : g_no_out_reg
      assign dout_a  = d1_a;
      assign dout_b  = d1_b;
      assign valid_a = v1_a;
      assign valid_b = v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: four instances share stimulus
// (0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE, 3 READ_FIRST with output register).
module tb_dual_port_ram_be;

  localparam int RF = 0;
  localparam int WF = 1;
  localparam int NC = 2;
  localparam int OR = 3;

  logic        clk;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  logic [15:0] dout_a [4];
  logic [15:0] dout_b [4];
  logic        valid_a [4];
  logic        valid_b [4];
  logic        init_busy [4];
  logic        collision [4];

  int total = 0;
  int bad   = 0;
  int n;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    dual_port_ram_be #(
      .DATA_W       (16),
      .ADDR_W       (4),
      .RD_MODE      ((k == 1) ? 1 : (k == 2) ? 2 : 0),
      .OUT_REG      ((k == 3) ? 1 : 0),
      .CLEAR_ON_RST (1),
      .INIT_VAL     (16'hA5A5)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en_a      (en_a),
      .we_a      (we_a),
      .be_a      (be_a),
      .addr_a    (addr_a),
      .din_a     (din_a),
      .dout_a    (dout_a[k]),
      .valid_a   (valid_a[k]),
      .en_b      (en_b),
      .we_b      (we_b),
      .be_b      (be_b),
      .addr_b    (addr_b),
      .din_b     (din_b),
      .dout_b    (dout_b[k]),
      .valid_b   (valid_b[k]),
      .init_busy (init_busy[k]),
      .collision (collision[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = 4'd0; din_a = 16'h0;
    en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = 4'd0; din_b = 16'h0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_dout_a", dout_a[RF], 16'h0000);
    chk("rst_valid_a", 16'(valid_a[RF]), 16'h0);
    chk("rst_dout_b_or", dout_b[OR], 16'h0000);
    chk("rst_collision", 16'(collision[RF]), 16'h0);
    chk("rst_busy", 16'(init_busy[RF]), 16'h1);

    // Clear sweep, with a read request issued while busy
    rst = 1'b0;
    en_a = 1'b1; addr_a = 4'd0;
    tick();
    n = 1;
    chk("busy_read_dropped", 16'(valid_a[RF]), 16'h0);
    idle();
    tick();
    n++;
    chk("busy_read_dropped_or", 16'(valid_a[OR]), 16'h0);
    while (init_busy[RF] && n < 40) begin
      tick();
      n++;
    end
    chk("busy_cycles", 16'(n), 16'd16);

    for (int i = 0; i < 16; i++) begin
      en_a = 1'b1; addr_a = 4'(i);
      tick();
      chk($sformatf("clear_rd_%0d", i), dout_a[RF], 16'hA5A5);
      chk($sformatf("clear_vld_%0d", i), 16'(valid_a[RF]), 16'h1);
    end
    idle();
    tick();
    chk("idle_valid_low", 16'(valid_a[RF]), 16'h0);
    chk("idle_dout_hold", dout_a[RF], 16'hA5A5);

    // Byte write, read back on port B
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; din_a = 16'h1234; be_a = 2'b01;
    tick();
    idle();
    en_b = 1'b1; addr_b = 4'd3;
    tick();
    chk("bytewr_rf_dout_b", dout_b[RF], 16'hA534);
    chk("bytewr_rf_valid_b", 16'(valid_b[RF]), 16'h1);
    chk("bytewr_or_early", 16'(valid_b[OR]), 16'h0);
    idle();
    tick();
    chk("bytewr_or_dout_b", dout_b[OR], 16'hA534);
    chk("bytewr_or_valid_b", 16'(valid_b[OR]), 16'h1);
    chk("bytewr_rf_valid_low", 16'(valid_b[RF]), 16'h0);

    // Read-during-write on port A at addr 5
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; din_a = 16'h0000; be_a = 2'b11;
    tick();
    idle();
    en_a = 1'b1; addr_a = 4'd3;
    tick();
    chk("nc_pre_read", dout_a[NC], 16'hA534);
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; din_a = 16'hBEEF; be_a = 2'b11;
    tick();
    idle();
    chk("rdw_rf_dout", dout_a[RF], 16'h0000);
    chk("rdw_rf_valid", 16'(valid_a[RF]), 16'h1);
    chk("rdw_wf_dout", dout_a[WF], 16'hBEEF);
    chk("rdw_wf_valid", 16'(valid_a[WF]), 16'h1);
    chk("rdw_nc_dout", dout_a[NC], 16'hA534);
    chk("rdw_nc_valid", 16'(valid_a[NC]), 16'h0);

    // Write/write collision on addr 7, overlapping masks
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; din_a = 16'h1111; be_a = 2'b11;
    en_b = 1'b1; we_b = 1'b1; addr_b = 4'd7; din_b = 16'h2222; be_b = 2'b10;
    tick();
    idle();
    chk("coll_pulse", 16'(collision[RF]), 16'h1);
    chk("coll_wf_dout_a", dout_a[WF], 16'h1111);
    chk("coll_wf_dout_b", dout_b[WF], 16'h1111);
    en_a = 1'b1; addr_a = 4'd7;
    tick();
    chk("coll_pulse_end", 16'(collision[RF]), 16'h0);
    chk("coll_mem", dout_a[RF], 16'h1111);

    // Disjoint masks: merge without a pulse
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; din_a = 16'h1111; be_a = 2'b01;
    en_b = 1'b1; we_b = 1'b1; addr_b = 4'd7; din_b = 16'h2222; be_b = 2'b10;
    tick();
    idle();
    chk("disj_no_pulse", 16'(collision[RF]), 16'h0);
    chk("disj_wf_dout_b", dout_b[WF], 16'h2211);
    en_a = 1'b1; addr_a = 4'd7;
    tick();
    chk("disj_mem", dout_a[RF], 16'h2211);

    // Cross-port read of a word being written by the other port
    en_a = 1'b1; addr_a = 4'd9;
    en_b = 1'b1; we_b = 1'b1; addr_b = 4'd9; din_b = 16'h5555; be_b = 2'b11;
    tick();
    idle();
    chk("xport_rf_old", dout_a[RF], 16'hA5A5);
    chk("xport_wf_old", dout_a[WF], 16'hA5A5);
    chk("xport_no_coll", 16'(collision[RF]), 16'h0);
    en_a = 1'b1; addr_a = 4'd9;
    tick();
    idle();
    chk("xport_new", dout_a[RF], 16'h5555);

    // Reset during a pending registered read, then mid-sweep
    en_a = 1'b1; addr_a = 4'd9;
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("rst2_or_valid", 16'(valid_a[OR]), 16'h0);
    chk("rst2_or_dout", dout_a[OR], 16'h0000);
    chk("rst2_rf_dout", dout_a[RF], 16'h0000);
    chk("rst2_busy", 16'(init_busy[OR]), 16'h1);
    rst = 1'b0;
    tick();
    chk("rst2_pending_dropped", 16'(valid_a[OR]), 16'h0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (init_busy[RF] && n < 40) begin
      tick();
      n++;
    end
    chk("restart_busy_cycles", 16'(n), 16'd16);
    en_a = 1'b1; addr_a = 4'd9;
    tick();
    idle();
    chk("restart_clear_rf", dout_a[RF], 16'hA5A5);
    chk("restart_or_latency", 16'(valid_a[OR]), 16'h0);
    tick();
    chk("restart_clear_or", dout_a[OR], 16'hA5A5);
    chk("restart_or_valid", 16'(valid_a[OR]), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
